temp_acq_filter: RTL and testbench
==================================

TEMP_ACQ_FILTER -- requirements
Module: temp_acq_filter

Interface
REQ-001 Parameter TIMEOUT, default 16, cycles to wait for adc_ack before declaring a channel fault.
REQ-002 clk  input  1  single system clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low; low forces reset state immediately.
REQ-004 sample_tick  input  1  one-cycle strobe requesting a new acquisition round.
REQ-005 adc_req  output  1  level request to the sensor ADC, held until ack or timeout.
REQ-006 adc_ch  output  1  channel select while adc_req high: 0 = external, 1 = room.
REQ-007 adc_ack  input  1  one-cycle acknowledge, adc_data valid in the same cycle.
REQ-008 adc_data  input  8  unsigned raw temperature, degrees C.
REQ-009 ETR  output  6  filtered external temperature, feeds the window-open driver.
REQ-010 RTR  output  6  filtered room temperature, feeds the window-open driver.
REQ-011 upd  output  1  one-cycle pulse when ETR/RTR are refreshed.
REQ-012 fault  output  1  high when any channel timed out in the last completed round.

Function
REQ-013 FSM states IDLE, REQ_EXT, REQ_ROOM, UPDATE; IDLE -> REQ_EXT on sample_tick; REQ_EXT -> REQ_ROOM on ack or timeout; REQ_ROOM -> UPDATE on ack or timeout; UPDATE -> IDLE unconditionally after one cycle.
REQ-014 sample_tick outside IDLE is ignored; no queuing.
REQ-015 adc_req is registered: high from the cycle after entry into REQ_EXT/REQ_ROOM until the cycle after ack or timeout; adc_ch is 0 in REQ_EXT, 1 in REQ_ROOM.
REQ-016 adc_ack is honoured only when adc_req is high; ack in IDLE or UPDATE is ignored.
REQ-017 On an honoured ack, adc_data is saturated to 63 when above 63 and pushed into that channel's 4-entry history; the oldest entry is discarded.
REQ-018 Timeout counter clears on entry to each request state and increments each cycle adc_req is high; reaching TIMEOUT without ack ends the state, pushes no sample and marks that channel failed for this round.
REQ-019 Ack in the same cycle the counter reaches TIMEOUT counts as an ack, not a timeout.
REQ-020 In UPDATE: ETR/RTR <= (sum of 4 history entries) >> 2, 8-bit sum, truncating; result always within 0..63.
REQ-021 upd pulses high for exactly the UPDATE cycle's following edge (one cycle), with ETR/RTR already valid.
REQ-022 fault is updated only in UPDATE: 1 if either channel failed this round, otherwise 0.
REQ-023 A failed channel's output is still recomputed from its unchanged history (value holds).
REQ-024 Round latency with immediate acks: sample_tick to upd = 5 cycles.

Reset
REQ-025 On rst low: state IDLE, adc_req 0, adc_ch 0, upd 0, fault 0, counter 0, all history entries 25, ETR 25, RTR 25.
REQ-026 Reset asserted mid-handshake drops adc_req asynchronously; the round is abandoned with no output update.

Structure
REQ-027 Shared package holds TEMP_RESET = 25, TEMP_MAX = 63, FSM state encoding and the default TIMEOUT.
REQ-028 One sub-module, temp_avg4: 4-entry history, push strobe, saturation and averaging; instantiated once per channel.

Verification
REQ-029 Reset release, no tick -> ETR = RTR = 25, adc_req 0, upd 0, fault 0.
REQ-030 Four rounds, ext ack data 0, room ack data 40, ack 1 cycle after req -> ETR 18, 12, 6, 0; RTR 28, 32, 36, 40; upd once per round, fault 0.
REQ-031 Room ack data 200 for four rounds -> RTR saturates at 63.
REQ-032 Ext never acked -> adc_req high exactly TIMEOUT cycles, then room requested, fault = 1, ETR unchanged; next round with both acks -> fault = 0.
REQ-033 sample_tick during REQ_ROOM, plus spurious adc_ack in IDLE -> ignored, exactly one upd, no history change.
REQ-034 rst pulled low while adc_req high -> adc_req 0 immediately, outputs 25, no upd.

Source files
------------

// File: rtl/temp_acq_filter_pkg.sv
// Shared definitions for the temperature acquisition filter.
// Holds the temperature constants, FSM encoding, channel indices,
// the default ADC timeout and the raw-to-6-bit saturation helper.
package temp_acq_filter_pkg;

  localparam int DATA_W      = 8;   // raw ADC word
  localparam int TEMP_W      = 6;   // filtered temperature word
  localparam int NUM_CH      = 2;
  localparam int CH_EXT      = 0;
  localparam int CH_ROOM     = 1;
  localparam int TEMP_RESET  = 25;
  localparam int TEMP_MAX    = 63;
  localparam int DEF_TIMEOUT = 16;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_REQ_EXT  = 2'd1;
  localparam logic [1:0] ST_REQ_ROOM = 2'd2;
  localparam logic [1:0] ST_UPDATE   = 2'd3;

  // Clamp an unsigned raw reading into the 0..63 output range.
  function automatic logic [TEMP_W-1:0] sat_temp(input logic [DATA_W-1:0] raw);
    return (raw > DATA_W'(TEMP_MAX)) ? TEMP_W'(TEMP_MAX) : raw[TEMP_W-1:0];
  endfunction

endpackage

// File: rtl/temp_acq_filter_avg4.sv
// temp_avg4: per-channel 4-deep sample history with moving average.
// Ports:
//   clk, rst   - clock, async active-low reset (history and avg to TEMP_RESET)
//   push, din  - push strobe and raw sample; din is saturated before storing
//   calc       - recompute avg from the current history
//   avg        - registered average, always within 0..63
module temp_avg4
  import temp_acq_filter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              calc,
  output logic [TEMP_W-1:0] avg
);

  logic [3:0][TEMP_W-1:0] hist;
  logic [7:0]             sum;

  // Four 6-bit entries sum to at most 252, so 8 bits never overflow.
  assign sum = {2'b00, hist[0]} + {2'b00, hist[1]} + {2'b00, hist[2]} + {2'b00, hist[3]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist <= {4{TEMP_W'(TEMP_RESET)}};
      avg  <= TEMP_W'(TEMP_RESET);
    end else begin
      // hist[3] is the oldest entry and falls off on each push
      if (push) hist <= {hist[2:0], sat_temp(din)};
      if (calc) avg  <= sum[7:2];
    end
  end

endmodule

// File: rtl/temp_acq_filter.sv
// temp_acq_filter: acquires external and room temperature from a shared
// ADC with a req/ack handshake, filters each channel with a 4-sample
// moving average and publishes ETR/RTR with a one-cycle upd pulse.
// Ports:
//   clk, rst          - clock, async active-low reset
//   sample_tick       - start an acquisition round (ignored unless idle)
//   adc_req, adc_ch   - registered ADC request and channel (0 ext, 1 room)
//   adc_ack, adc_data - one-cycle ack with same-cycle data
//   ETR, RTR          - filtered external / room temperature
//   upd               - one-cycle pulse when ETR/RTR refresh
//   fault             - a channel timed out in the last completed round
module temp_acq_filter
  import temp_acq_filter_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_tick,
  output logic              adc_req,
  output logic              adc_ch,
  input  logic              adc_ack,
  input  logic [DATA_W-1:0] adc_data,
  output logic [TEMP_W-1:0] ETR,
  output logic [TEMP_W-1:0] RTR,
  output logic              upd,
  output logic              fault
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [1:0]                   state;
  logic [CNT_W-1:0]             cnt;
  logic [CNT_W-1:0]             cnt_inc;
  logic [NUM_CH-1:0]            failed;
  logic [NUM_CH-1:0]            push;
  logic [NUM_CH-1:0][TEMP_W-1:0] temp;
  logic                         in_req;
  logic                         cur_ch;
  logic                         ack_ok;
  logic                         tmo;

  assign in_req  = (state == ST_REQ_EXT) || (state == ST_REQ_ROOM);
  assign cur_ch  = (state == ST_REQ_ROOM);
  assign cnt_inc = cnt + CNT_W'(1);
  // Ack wins over a timeout landing in the same cycle.
  assign ack_ok  = in_req && adc_req && adc_ack;
  assign tmo     = in_req && adc_req && !adc_ack && (cnt_inc == CNT_W'(TIMEOUT));

  assign push[CH_EXT]  = ack_ok && !cur_ch;
  assign push[CH_ROOM] = ack_ok &&  cur_ch;

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch
      temp_avg4 u_avg (
        .clk  (clk),
        .rst  (rst),
        .push (push[g]),
        .din  (adc_data),
        .calc (state == ST_UPDATE),
        .avg  (temp[g])
      );
    end
  endgenerate

  assign ETR = temp[CH_EXT];
  assign RTR = temp[CH_ROOM];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      adc_req <= 1'b0;
      adc_ch  <= 1'b0;
      upd     <= 1'b0;
      fault   <= 1'b0;
      cnt     <= '0;
      failed  <= '0;
    end else begin
      upd <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sample_tick) begin
            state  <= ST_REQ_EXT;
            cnt    <= '0;
            failed <= '0;
          end
        end
        ST_REQ_EXT, ST_REQ_ROOM: begin
          // adc_req low here means the state was just entered: raise it now
          // so the request is a clean registered level.
          if (!adc_req) begin
            adc_req <= 1'b1;
            adc_ch  <= cur_ch;
          end else if (ack_ok || tmo) begin
            adc_req <= 1'b0;
            cnt     <= '0;
            if (tmo) failed[cur_ch] <= 1'b1;
            state   <= cur_ch ? ST_UPDATE : ST_REQ_ROOM;
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_UPDATE: begin
          // Averages latch on this same edge, so upd and data align.
          upd    <= 1'b1;
          fault  <= |failed;
          adc_ch <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_temp_acq_filter.sv
module tb_temp_acq_filter;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sample_tick = 1'b0;
  logic       adc_req, adc_ch, adc_ack;
  logic [7:0] adc_data;
  logic [5:0] ETR, RTR;
  logic       upd, fault;

  logic       resp_ack = 1'b0, spur_ack = 1'b0;
  logic [7:0] resp_data = 8'd0, spur_data = 8'd0;

  assign adc_ack  = resp_ack | spur_ack;
  assign adc_data = spur_ack ? spur_data : resp_data;

  temp_acq_filter #(.TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_tick (sample_tick),
    .adc_req     (adc_req),
    .adc_ch      (adc_ch),
    .adc_ack     (adc_ack),
    .adc_data    (adc_data),
    .ETR         (ETR),
    .RTR         (RTR),
    .upd         (upd),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, n_upd = 0, n_exp = 0;

  typedef struct packed {
    logic [5:0] etr;
    logic [5:0] rtr;
    logic       flt;
  } exp_t;
  exp_t sb[$];

  // ADC model configuration
  bit         ext_en = 1'b1, room_en = 1'b1;
  int         ack_dly = 1;
  logic [7:0] ext_val = 8'd0, room_val = 8'd40;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  // ADC responder: acks ack_dly cycles after seeing adc_req, one-cycle pulse.
  initial begin
    int seen;
    seen = 0;
    forever begin
      @(negedge clk);
      if (resp_ack) begin
        resp_ack = 1'b0;
        seen = 0;
      end else if (rst && adc_req) begin
        if ((adc_ch ? room_en : ext_en) && seen >= ack_dly) begin
          resp_ack  = 1'b1;
          resp_data = adc_ch ? room_val : ext_val;
        end else begin
          seen++;
        end
      end else begin
        seen = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on each upd pulse.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && upd) begin
        n_upd++;
        checks++;
        if (prev) begin
          failures++;
          $display("FAIL upd_width upd high on consecutive cycles");
        end
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL upd_unexpected got ETR=%0d RTR=%0d fault=%0d exp no update", ETR, RTR, fault);
        end else begin
          e = sb.pop_front();
          if (ETR !== e.etr || RTR !== e.rtr || fault !== e.flt) begin
            failures++;
            $display("FAIL update got ETR=%0d RTR=%0d fault=%0d exp ETR=%0d RTR=%0d fault=%0d",
                     ETR, RTR, fault, e.etr, e.rtr, e.flt);
          end
        end
      end
      prev = rst && upd;
    end
  end

  task automatic expect_upd(input int e, input int r, input int f);
    exp_t x;
    x.etr = 6'(e);
    x.rtr = 6'(r);
    x.flt = f[0];
    sb.push_back(x);
    n_exp++;
  endtask

  task automatic pulse_tick();
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic wait_upd();
    int start, k;
    start = n_upd;
    k = 0;
    while (n_upd == start && k < 300) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (n_upd == start) begin
      failures++;
      $display("FAIL upd_wait got no upd exp upd within 300 cycles");
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run_round(input int e, input int r, input int f);
    expect_upd(e, r, f);
    pulse_tick();
    wait_upd();
  endtask

  task automatic wait_req(input logic ch);
    int k;
    k = 0;
    while (!(adc_req && adc_ch == ch) && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("req_seen", int'(adc_req && adc_ch == ch), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int hi, base, lat;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_etr", ETR, 25);
    chk("rst_rtr", RTR, 25);
    chk("rst_req", adc_req, 0);
    chk("rst_upd", upd, 0);
    chk("rst_fault", fault, 0);

    // Ext 0, room 40 for four rounds
    run_round(18, 28, 0);
    run_round(12, 32, 0);
    run_round(6, 36, 0);
    run_round(0, 40, 0);

    // Room reads 200 -> saturated to 63
    room_val = 8'd200;
    run_round(0, 45, 0);
    run_round(0, 51, 0);
    run_round(0, 57, 0);
    run_round(0, 63, 0);

    // Ext never acked: timeout after TMO request cycles
    do_reset();
    room_val = 8'd40;
    ext_en = 1'b0;
    expect_upd(25, 28, 1);
    pulse_tick();
    wait_req(1'b0);
    hi = 0;
    while (adc_req && hi < 100) begin
      hi++;
      @(negedge clk);
    end
    chk("tmo_req_cycles", hi, TMO);
    wait_req(1'b1);
    wait_upd();
    ext_en = 1'b1;
    run_round(18, 32, 0);

    // Tick during REQ_ROOM is dropped
    expect_upd(12, 36, 0);
    pulse_tick();
    wait_req(1'b1);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    wait_upd();
    repeat (20) @(negedge clk);

    // Spurious ack in IDLE must not touch history
    spur_data = 8'd63;
    spur_ack  = 1'b1;
    @(negedge clk);
    spur_ack  = 1'b0;
    repeat (5) @(negedge clk);
    chk("spur_etr", ETR, 12);
    chk("spur_rtr", RTR, 36);
    run_round(6, 40, 0);

    // Reset while adc_req high
    base = n_upd;
    pulse_tick();
    wait_req(1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_req", adc_req, 0);
    chk("arst_etr", ETR, 25);
    chk("arst_rtr", RTR, 25);
    chk("arst_upd", upd, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    chk("arst_no_upd", n_upd, base);
    chk("arst_req_idle", adc_req, 0);

    // Latency with immediate acks: tick edge to upd edge = 5
    ack_dly = 0;
    expect_upd(18, 28, 0);
    @(negedge clk);
    sample_tick = 1'b1;
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
    lat = 0;
    while (!upd && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, 5);
    repeat (5) @(negedge clk);

    chk("sb_empty", sb.size(), 0);
    chk("upd_count", n_upd, n_exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
